multi_sgl_sync: RTL and testbench
=================================

# multi_sgl_sync

Parametrised multi-channel synchroniser that brings control levels from a slow or asynchronous clock region into the fast clock region. Each channel has a configurable-depth flop chain, an optional glitch filter, and an edge detector producing single-cycle pulses. The selected edge is rising, falling or both. The block replaces single-bit, rising-edge-only level-to-pulse synchronisers at slow-to-fast crossings, and feeds fast-domain FSM start and ack inputs.

## Interface
- CH, 4: number of independent channels, ≥1
- STG, 2: synchroniser flops per channel, ≥2
- EDGE, 0: pulse mode. 0 = rising, 1 = falling, 2 = both edges
- FILT, 3: consecutive fast cycles a new level must persist before acceptance, ≥1; used only with filter compiled in
- f_clk  in  1  fast-region clock; all flops rise on posedge
- frst_n  in  1  asynchronous active-low reset, applied on negedge
- i_sgl  in  CH  levels from the slow region; asynchronous to f_clk
- o_lvl  out  CH  synchronised (and filtered) level per channel
- o_sgl  out  CH  one-f_clk-cycle event pulse per channel
- o_any  out  1  OR-reduction of o_sgl

## Operation
- Per channel, i_sgl[i] enters a STG-flop chain. sync[i] is the last flop.
- The filter stage yields lvl[i], driven on o_lvl[i]:
  - Filter in: a per-channel counter cnt (width clog2(FILT+1)) runs.
  - If sync[i] == lvl[i], then cnt <= 0.
  - Otherwise, if cnt == FILT-1, then lvl[i] <= sync[i] and cnt <= 0.
  - Otherwise, cnt <= cnt+1.
  - Any agreement cycle before acceptance discards progress: the counter returns to 0.
  - Filter out: lvl[i] is sync[i], with no extra flop.
- prv[i] <= lvl[i] every cycle.
- o_sgl[i] is combinational from flops:
  - EDGE=0: lvl & ~prv
  - EDGE=1: ~lvl & prv
  - EDGE=2: lvl ^ prv
- Channels are fully independent. Simultaneous events on several channels each produce their own pulse in the same cycle.
- o_any = |o_sgl.
- Illegal parameter values must be flagged with an elaboration-time error. These are STG<2, FILT<1, CH<1, or EDGE>2.

## Timing
- Reset: all chain flops, lvl, prv and cnt are 0. Therefore o_lvl=0, o_sgl=0, o_any=0.
- Release of frst_n mid-activity behaves as from power-up. An input already high at release produces a rising pulse after the normal latency.
- Latency is counted from the first posedge sampling a stable new i_sgl value as edge 1:
  - Filter out: o_lvl changes after edge STG. o_sgl is high for exactly the cycle between edge STG and edge STG+1.
  - Filter in: o_lvl changes after edge STG+FILT. The pulse follows in the same way, one cycle wide.
- A sync-level excursion of fewer than FILT cycles produces no o_lvl change and no pulse.
- Exactly FILT cycles is accepted.
- Input toggling is legal at any rate. With the filter out, pulses follow each settled synchronised transition. The source must hold each level ≥STG+1 fast cycles for guaranteed capture; this is a system rule and is not checked.
- Pulse width is always exactly 1 cycle. A level held indefinitely never re-pulses.

## Configuration
- SGL_SYNC_FILT_EN:
  - Defined: glitch filter and cnt registers are present. Latency is STG+FILT.
  - Undefined: no counters, lvl = sync, and latency is STG. FILT is ignored but must still be legal.

## Test plan
- Reset and rise, filter out, CH=4, STG=2, EDGE=0:
  - Stimulus: hold frst_n=0 and assert i_sgl=4'b0101; release frst_n, then hold i_sgl steady.
  - Required: o_sgl=4'b0101 for exactly one cycle, after the 2nd posedge after release; o_lvl=4'b0101 thereafter; o_any pulses once.
- Falling and both modes:
  - Stimulus: EDGE=1, i_sgl[2] taken 1→0 after being high 10 cycles.
  - Required: a single o_sgl[2] pulse, and none on the earlier rise.
  - Stimulus: EDGE=2, same waveform.
  - Required: two pulses, one per transition.
- Filter reject, SGL_SYNC_FILT_EN, FILT=3:
  - Stimulus: i_sgl[0] high for 2 cycles, then low.
  - Required: o_lvl[0] stays 0 and no pulse.
- Filter accept, same build:
  - Stimulus: i_sgl[0] high for 3+ cycles.
  - Required: o_lvl[0] rises after edge 5 (STG+FILT), and a single pulse.
- Simultaneous multi-channel: CH=4, all inputs rise together.
  - Required: o_sgl=4'b1111 in one cycle; o_any high for exactly that cycle.
- Reset mid-filter:
  - Stimulus: frst_n asserted while cnt=2 on channel 1.
  - Required: immediate o_lvl=0, o_sgl=0, cnt=0. After release, acceptance needs the full STG+FILT cycles again.

Source files
------------

// File: rtl/multi_sgl_sync.sv
// Multi-channel slow-to-fast level synchroniser with edge-to-pulse conversion.
// Optional persistence (glitch) filter is compiled in with `define SGL_SYNC_FILT_EN.
module multi_sgl_sync #(
   parameter int CH   = 4,
   parameter int STG  = 2,
   parameter int EDGE = 0,
   parameter int FILT = 3
) (
   input  logic          f_clk,
   input  logic          frst_n,
   input  logic [CH-1:0] i_sgl,
   output logic [CH-1:0] o_lvl,
   output logic [CH-1:0] o_sgl,
   output logic          o_any
);

   generate
      if (CH < 1 || STG < 2 || FILT < 1 || EDGE < 0 || EDGE > 2) begin : g_bad_param
         $error("multi_sgl_sync: illegal parameters CH=%0d STG=%0d EDGE=%0d FILT=%0d",
                CH, STG, EDGE, FILT);
      end
   endgenerate

   logic [STG-1:0][CH-1:0] chain_p0;
   logic [CH-1:0]          sync_p0;
   logic [CH-1:0]          lvl_p1;
   logic [CH-1:0]          prv_p2;

   // Stage 0: metastability chain, entry at index 0, synchronised level at the top
   always_ff @(posedge f_clk or negedge frst_n) begin
      if (!frst_n) begin
         chain_p0 <= '0;
      end else begin
         chain_p0 <= {chain_p0[STG-2:0], i_sgl};
      end
   end

   assign sync_p0 = chain_p0[STG-1];

   // Stage 1: accepted level, optionally held back until the new level persists FILT cycles
`ifdef SGL_SYNC_FILT_EN
   localparam int CW = $clog2(FILT + 1);

   for (genvar i = 0; i < CH; i++) begin : g_filt
      logic [CW-1:0] cnt;
      logic          lvl_ch;

      always_ff @(posedge f_clk or negedge frst_n) begin
         if (!frst_n) begin
            cnt    <= '0;
            lvl_ch <= 1'b0;
         end else if (sync_p0[i] == lvl_ch) begin
            cnt    <= '0;
         end else if (cnt == CW'(FILT - 1)) begin
            lvl_ch <= sync_p0[i];
            cnt    <= '0;
         end else begin
            cnt    <= cnt + CW'(1);
         end
      end

      assign lvl_p1[i] = lvl_ch;
   end
`else
   assign lvl_p1 = sync_p0;
`endif

   // Stage 2: previous accepted level for edge detection
   always_ff @(posedge f_clk or negedge frst_n) begin
      if (!frst_n) begin
         prv_p2 <= '0;
      end else begin
         prv_p2 <= lvl_p1;
      end
   end

   generate
      if (EDGE == 0) begin : g_rise
         assign o_sgl = lvl_p1 & ~prv_p2;
      end else if (EDGE == 1) begin : g_fall
         assign o_sgl = ~lvl_p1 & prv_p2;
      end else begin : g_both
         assign o_sgl = lvl_p1 ^ prv_p2;
      end
   endgenerate

   assign o_lvl = lvl_p1;
   assign o_any = |o_sgl;

endmodule

// File: tb/tb_multi_sgl_sync.sv
// Directed bench for multi_sgl_sync: three instances (rising, falling, both edges)
// share one input bus; expected latencies follow the SGL_SYNC_FILT_EN build.
module tb_multi_sgl_sync;

   localparam int CH   = 4;
   localparam int STG  = 2;
   localparam int FILT = 3;
`ifdef SGL_SYNC_FILT_EN
   localparam int LAT  = STG + FILT;
   localparam bit FILT_ON = 1'b1;
`else
   localparam int LAT  = STG;
   localparam bit FILT_ON = 1'b0;
`endif

   logic          f_clk;
   logic          frst_n;
   logic [CH-1:0] i_sgl;
   logic [CH-1:0] lvl_r, sgl_r, lvl_f, sgl_f, lvl_b, sgl_b;
   logic          any_r, any_f, any_b;

   int n_chk;
   int n_err;

   int kk;
   int np_r, np_f, np_b, nany;
   int first_r, first_f, first_b, lvl_at;
   logic [CH-1:0] any_val;

   multi_sgl_sync #(.CH(CH), .STG(STG), .EDGE(0), .FILT(FILT)) u_r (
      .f_clk(f_clk), .frst_n(frst_n), .i_sgl(i_sgl),
      .o_lvl(lvl_r), .o_sgl(sgl_r), .o_any(any_r));

   multi_sgl_sync #(.CH(CH), .STG(STG), .EDGE(1), .FILT(FILT)) u_f (
      .f_clk(f_clk), .frst_n(frst_n), .i_sgl(i_sgl),
      .o_lvl(lvl_f), .o_sgl(sgl_f), .o_any(any_f));

   multi_sgl_sync #(.CH(CH), .STG(STG), .EDGE(2), .FILT(FILT)) u_b (
      .f_clk(f_clk), .frst_n(frst_n), .i_sgl(i_sgl),
      .o_lvl(lvl_b), .o_sgl(sgl_b), .o_any(any_b));

   initial f_clk = 1'b0;
   always #5 f_clk = ~f_clk;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", tag, got, got, exp, exp);
      end
   endtask

   task automatic step();
      @(posedge f_clk);
      #1;
   endtask

   task automatic clear();
      kk = 0; np_r = 0; np_f = 0; np_b = 0; nany = 0;
      first_r = -1; first_f = -1; first_b = -1; lvl_at = -1; any_val = '0;
   endtask

   // Steps n cycles, tallying pulses on channel ch of each instance and o_any of u_r.
   task automatic observe(input int n, input int ch);
      for (int k = 0; k < n; k++) begin
         step();
         kk++;
         if (sgl_r[ch]) begin np_r++; if (first_r < 0) first_r = kk; end
         if (sgl_f[ch]) begin np_f++; if (first_f < 0) first_f = kk; end
         if (sgl_b[ch]) begin np_b++; if (first_b < 0) first_b = kk; end
         if (any_r) begin nany++; if (nany == 1) any_val = sgl_r; end
         if (lvl_r[ch] && lvl_at < 0) lvl_at = kk;
      end
   endtask

   initial begin
      n_chk = 0;
      n_err = 0;
      clear();

      // Reset with inputs already high
      frst_n = 1'b0;
      i_sgl  = 4'b0101;
      repeat (3) step();
      chk("rst_lvl", 32'(lvl_r), 32'(4'b0000));
      chk("rst_sgl", 32'(sgl_r), 32'(4'b0000));
      chk("rst_any", 32'(any_r), 32'd0);

      frst_n = 1'b1;
      repeat (LAT - 1) step();
      chk("rise_pre_sgl", 32'(sgl_r), 32'(4'b0000));
      step();
      chk("rise_sgl", 32'(sgl_r), 32'(4'b0101));
      chk("rise_any", 32'(any_r), 32'd1);
      chk("rise_f_none", 32'(sgl_f), 32'(4'b0000));
      step();
      chk("rise_post_sgl", 32'(sgl_r), 32'(4'b0000));
      chk("rise_post_lvl", 32'(lvl_r), 32'(4'b0101));
      clear();
      observe(10, 0);
      chk("hold_no_repulse", 32'(nany), 32'd0);
      chk("hold_lvl", 32'(lvl_r), 32'(4'b0101));

      // Falling / both edge modes on channel 2
      i_sgl = 4'b0000;
      observe(12, 2);
      clear();
      i_sgl = 4'b0100;
      observe(10, 2);
      chk("ch2_rise_r_cnt", 32'(np_r), 32'd1);
      chk("ch2_rise_r_at", 32'(first_r), 32'(LAT));
      chk("ch2_rise_f_cnt", 32'(np_f), 32'd0);
      chk("ch2_rise_b_cnt", 32'(np_b), 32'd1);
      clear();
      i_sgl = 4'b0000;
      observe(10, 2);
      chk("ch2_fall_r_cnt", 32'(np_r), 32'd0);
      chk("ch2_fall_f_cnt", 32'(np_f), 32'd1);
      chk("ch2_fall_f_at", 32'(first_f), 32'(LAT));
      chk("ch2_fall_b_cnt", 32'(np_b), 32'd1);
      chk("ch2_fall_b_at", 32'(first_b), 32'(LAT));

      // Two-cycle excursion on channel 0
      clear();
      i_sgl = 4'b0001;
      observe(2, 0);
      i_sgl = 4'b0000;
      observe(12, 0);
      chk("short_r_cnt", 32'(np_r), FILT_ON ? 32'd0 : 32'd1);
      chk("short_b_cnt", 32'(np_b), FILT_ON ? 32'd0 : 32'd2);
      chk("short_lvl_at", 32'(lvl_at), FILT_ON ? 32'hFFFF_FFFF : 32'd2);

      // Excursion of exactly FILT cycles on channel 0
      clear();
      i_sgl = 4'b0001;
      observe(FILT, 0);
      i_sgl = 4'b0000;
      observe(12, 0);
      chk("exact_lvl_at", 32'(lvl_at), 32'(LAT));
      chk("exact_r_at", 32'(first_r), 32'(LAT));
      chk("exact_r_cnt", 32'(np_r), 32'd1);
      chk("exact_b_cnt", 32'(np_b), 32'd2);

      // All channels rise together
      clear();
      i_sgl = 4'b1111;
      observe(10, 3);
      chk("multi_any_cnt", 32'(nany), 32'd1);
      chk("multi_any_val", 32'(any_val), 32'(4'b1111));
      chk("multi_at", 32'(first_r), 32'(LAT));
      chk("multi_lvl", 32'(lvl_r), 32'(4'b1111));

      // Reset part-way through acceptance on channel 1
      i_sgl = 4'b0000;
      observe(12, 1);
      clear();
      i_sgl = 4'b0010;
      observe(STG + 2, 1);
      #2 frst_n = 1'b0;
      #1;
      chk("mid_rst_lvl", 32'(lvl_r), 32'(4'b0000));
      chk("mid_rst_sgl", 32'(sgl_b), 32'(4'b0000));
      chk("mid_rst_any", 32'(any_b), 32'd0);
      step();
      step();
      frst_n = 1'b1;
      clear();
      observe(10, 1);
      chk("post_rst_lvl_at", 32'(lvl_at), 32'(LAT));
      chk("post_rst_r_at", 32'(first_r), 32'(LAT));
      chk("post_rst_r_cnt", 32'(np_r), 32'd1);

      $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
      $finish;
   end

endmodule
